// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared CPU constants, fetch state encoding and jump-control codes
package instruction_fetch_pkg;

   localparam logic [15:0] NOP = 16'h0800;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } fetch_state_t;

   // Codes the control unit decodes into a taken redirect.
   typedef enum logic [2:0] {
      JMP_NONE = 3'd0,
      JMP_JUMP = 3'd1,
      JMP_JR   = 3'd2,
      JMP_BEQ  = 3'd3,
      JMP_BNE  = 3'd4,
      JMP_BLT  = 3'd5
   } jump_ctrl_t;

   function automatic logic [15:0] pc_inc(input logic [15:0] a);
      return a + 16'd1;
   endfunction

endpackage

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, imem handshake, flush handling and EPC
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [15:0] INT_VECTOR = 16'h0008
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ready,
   input  logic [15:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_target,
   input  logic        int_take,
   input  logic        eret_take,
   output logic [15:0] instruction,
   output logic        inst_valid,
   output logic [15:0] pc_out,
   output logic [15:0] epc
);

   fetch_state_t state, state_n;
   logic [15:0]  pc, pc_n, req_addr, req_addr_n;
   logic [15:0]  instr_n, pc_out_n, epc_n;
   logic         valid_n, load, flush;
   logic [15:0]  target;

   assign flush  = int_take | eret_take | redirect;
   assign target = int_take  ? INT_VECTOR :
                   eret_take ? epc        : redirect_target;

   assign imem_req  = (state == ST_FETCH) || (state == ST_DRAIN);
   assign imem_addr = req_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         pc          <= RESET_PC;
         req_addr    <= RESET_PC;
         epc         <= 16'h0000;
         instruction <= NOP;
         inst_valid  <= 1'b0;
         pc_out      <= 16'h0000;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         req_addr    <= req_addr_n;
         epc         <= epc_n;
         instruction <= instr_n;
         inst_valid  <= valid_n;
         pc_out      <= pc_out_n;
      end
   end

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      req_addr_n = req_addr;
      instr_n    = instruction;
      pc_out_n   = pc_out;
      valid_n    = inst_valid;
      epc_n      = epc;
      load       = 1'b0;

      if (inst_valid && !stall) begin
         valid_n = 1'b0;
         instr_n = NOP;
      end

      case (state)
         ST_IDLE: begin
            state_n = ST_FETCH;
            if (flush) req_addr_n = target;
         end
         ST_FETCH: begin
            if (imem_ready) begin
               if (flush) begin
                  req_addr_n = target;
               end else if (!inst_valid || !stall) begin
                  load       = 1'b1;
                  pc_n       = pc_inc(req_addr);
                  req_addr_n = pc_inc(req_addr);
                  state_n    = stall ? ST_HOLD : ST_FETCH;
               end else begin
                  // Output full and stalled: drop the word, refetch it from pc later.
                  state_n = ST_HOLD;
               end
            end else if (flush) begin
               state_n = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (imem_ready) begin
               state_n    = ST_FETCH;
               req_addr_n = flush ? target : pc;
            end
         end
         ST_HOLD: begin
            if (flush) begin
               state_n    = ST_FETCH;
               req_addr_n = target;
            end else if (!stall) begin
               state_n    = ST_FETCH;
               req_addr_n = pc;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      if (load) begin
         instr_n  = imem_rdata;
         pc_out_n = req_addr;
         valid_n  = 1'b1;
      end

      if (flush) begin
         pc_n    = target;
         valid_n = 1'b0;
         instr_n = NOP;
      end

      if (int_take) epc_n = pc_inc(pc_out);
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the 16-bit pipeline, directly upstream of the instruction decoder. It owns the PC and issues word reads to instruction memory over a req/ready handshake. It presents one instruction per cycle, with its PC and a valid flag, to the decoder, and supplies a NOP when it has nothing valid. It redirects on taken jumps/branches, interrupt entry and eret, and keeps the EPC.

## Interface
- RESET_PC, 16'h0000, first fetch address after reset
- INT_VECTOR, 16'h0008, fetch address on interrupt entry
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- imem_req  out  1  read request
- imem_addr  out  16  word address; stable while imem_req high and imem_ready low
- imem_ready  in  1  read complete this cycle; imem_rdata valid
- imem_rdata  in  16  instruction word
- stall  in  1  decoder cannot accept; hold output
- redirect  in  1  taken branch/jump this cycle
- redirect_target  in  16  branch/jump target
- int_take  in  1  interrupt accepted this cycle
- eret_take  in  1  return from interrupt this cycle
- instruction  out  16  to decoder; 16'h0800 (NOP) when not valid
- inst_valid  out  1  instruction/pc_out meaningful
- pc_out  out  16  address of instruction
- epc  out  16  saved return address

## Operation
- Registers: pc (next address to request), req_addr, out register (instruction, pc_out, inst_valid), epc, state.
- States:
  - IDLE: one cycle after reset; no request; goes to FETCH.
  - FETCH: imem_req=1, imem_addr=req_addr.
  - DRAIN: outstanding request whose data will be discarded; imem_req=1.
  - HOLD: output full and stalled; imem_req=0.
- Consume condition: inst_valid && !stall.
- FETCH with imem_ready and no flush:
  - Load the out register with imem_rdata and pc_out=req_addr, and set inst_valid.
  - pc, req_addr <= req_addr+1, wrapping 16'hFFFF to 16'h0000.
  - If stall is high, go to HOLD; otherwise stay in FETCH.
- Only issue a new request when the out register is empty or being consumed.
- HOLD: when stall falls, go to FETCH with req_addr=pc.
- Flush events, priority rst > int_take > eret_take > redirect. The highest-priority event sets the new target:
  - int_take: INT_VECTOR, and epc <= pc_out+1.
  - eret_take: epc.
  - redirect: redirect_target.
- Every flush:
  - clears inst_valid next cycle, so the output becomes NOP;
  - sets pc <= target.
- Flush routing by state:
  - FETCH with imem_ready in the same cycle: discard data; req_addr <= target; stay in FETCH.
  - FETCH without imem_ready: go to DRAIN; req_addr stays unchanged, because the address is held stable.
  - HOLD or IDLE: go to FETCH with req_addr=target.
- DRAIN: on imem_ready, discard the data and go to FETCH with req_addr=pc. A further flush during DRAIN overwrites pc; the last flush wins.
- Flush and stall in the same cycle: flush wins; the out register is cleared regardless of stall.
- Reset values:
  - state=IDLE, pc=req_addr=RESET_PC, epc=16'h0000;
  - instruction=16'h0800, inst_valid=0, pc_out=16'h0000, imem_req=0.
- Reset mid-request: the request is abandoned. The memory interface must tolerate imem_req dropping.

## Timing
- Zero-wait memory (ready in the request cycle): a request in cycle N gives a valid instruction in cycle N+1. Throughput is one instruction per cycle.
- Flush sampled in cycle N: inst_valid=0 in N+1. With zero-wait memory, the target instruction is valid in N+2.
- Flush during a W-cycle wait: the target request starts the cycle after the drained ready.
- Outputs are registered; imem_req and imem_addr are decoded from state and req_addr registers only, with no input-to-output combinational path.

## Structure
- A shared CPU package holds:
  - NOP constant 16'h0800;
  - fetch state encoding (IDLE, FETCH, DRAIN, HOLD);
  - the jump-control codes used by the control unit that generates redirect.
- No sub-module; the block is a flat FSM plus registers.

## Test plan
- Reset, then zero-wait memory returning mem[a]=a^16'h5A00: the instruction stream is 5A00,5A01,… from cycle 2; pc_out=0,1,…; inst_valid held 1.
- Assert stall for 3 cycles while inst_valid: instruction and pc_out frozen, imem_req=0 after the current fetch. Release: the next pc_out is the held value+1, with no skip or duplicate.
- redirect=1, target=16'h0040, while a 3-wait request to 16'h0005 is outstanding:
  - imem_addr stays 16'h0005 until ready, and that data is discarded;
  - the next request is to 16'h0040, and the first valid pc_out is 16'h0040.
- int_take with pc_out=16'h0012, then later eret_take: epc=16'h0013; fetch goes to 16'h0008, then resumes at 16'h0013.
- Same cycle int_take and redirect (target 16'h0100): the vector 16'h0008 is fetched and the redirect is ignored. Same cycle eret_take and redirect: the epc is fetched.
- Fetch wrap at req_addr=16'hFFFF: the next pc_out is 16'h0000. Assert rst mid-wait: the next cycle has imem_req=0, output NOP, pc=RESET_PC.
